// File: rtl/fifo_burst_reader_if.sv
// FIFO read port and output stream of the burst reader, bundled for port connection.
// The master side is the reader; the slave side is the FIFO plus the downstream consumer.
interface fifo_burst_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_underflow;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output fifo_rd, out_valid, out_data, out_last,
    input  fifo_data, fifo_empty, fifo_underflow, out_ready
  );

  modport slave (
    input  fifo_rd, out_valid, out_data, out_last,
    output fifo_data, fifo_empty, fifo_underflow, out_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a programmed number of words from an 8-deep synchronous FIFO onto a valid/ready
// stream, hiding the FIFO's one-cycle read latency behind a two-entry skid buffer.
module fifo_burst_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    burst_len,
  fifo_burst_reader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    count_sent,
  output logic                err_underflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  sent_q, sent_d;
  logic [DATA_W-1:0] skid_q [2];
  logic [DATA_W-1:0] skid_d [2];
  logic [1:0]        occ_q, occ_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              rdIssue;
  logic              pop;
  logic              push;

  // A read may go out only if the buffer can still hold it once the in-flight word lands.
  always_comb begin
    pop     = (occ_q != 2'd0) && bus.out_ready;
    push    = pend_q;
    rdIssue = (state_q == RUN) && !bus.fifo_empty && (issued_q < len_q) &&
              (({1'b0, occ_q} + {2'b00, pend_q}) <= (3'd1 + {2'b00, pop}));
  end

  assign bus.fifo_rd   = rdIssue;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = skid_q[0];
  assign bus.out_last  = (occ_q != 2'd0) && (sent_q == len_q - LEN_W'(1));
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign count_sent    = sent_q;
  assign err_underflow = err_q;

  // Skid buffer: entry 0 is always the head shown on the stream.
  always_comb begin
    skid_d = skid_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        skid_d[occ_q[0]] = bus.fifo_data;
        occ_d            = occ_q + 2'd1;
      end
      2'b01: begin
        skid_d[0] = skid_q[1];
        occ_d     = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          skid_d[0] = bus.fifo_data;
        end else begin
          skid_d[0] = skid_q[1];
          skid_d[1] = bus.fifo_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    err_d    = err_q;
    pend_d   = rdIssue;
    if (rdIssue) begin
      issued_d = issued_q + LEN_W'(1);
    end
    if (pop) begin
      sent_d = sent_q + LEN_W'(1);
    end
    if (busy && bus.fifo_underflow) begin
      err_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = burst_len;
          issued_d = '0;
          sent_d   = '0;
          err_d    = 1'b0;
          state_d  = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issued_q == len_q) begin
          state_d = DRAIN;
        end
      end
      // Leave on the same edge that completes the final handshake.
      DRAIN: begin
        if ((occ_d == 2'd0) && !pend_d && (sent_d == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      sent_q    <= '0;
      occ_q     <= 2'd0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      sent_q    <= sent_d;
      occ_q     <= occ_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      skid_q[0] <= skid_d[0];
      skid_q[1] <= skid_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rdIssue && bus.fifo_empty));
      assert (!(push && !pop && (occ_q == 2'd2)));
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT while a per-cycle
// reference model predicts beats, last flags, busy, done and the sticky error flag.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] burstLen = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] countSent;
  logic       errUnderflow;
  logic       outReady = 1'b0;
  logic       wrEn = 1'b0;
  logic [7:0] wrData = 8'd0;
  logic       fifoClr = 1'b0;
  logic       forceUnder = 1'b0;

  fifo_burst_reader_if #(.DATA_W(8)) bus ();

  fifo_burst_reader #(.DATA_W(8), .LEN_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .burst_len     (burstLen),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .count_sent    (countSent),
    .err_underflow (errUnderflow)
  );

  always #5 clk = ~clk;

  // Behavioural 8-deep FIFO with registered read data one cycle after rd.
  logic [7:0] fifoQ[$];
  int         fifoCnt = 0;
  logic [7:0] fifoDout = 8'd0;
  logic       fifoUnderQ = 1'b0;

  always @(posedge clk) begin
    if (fifoClr) begin
      fifoQ.delete();
      fifoUnderQ <= 1'b0;
    end else begin
      fifoUnderQ <= 1'b0;
      if (bus.fifo_rd) begin
        if (fifoQ.size() == 0) fifoUnderQ <= 1'b1;
        else fifoDout <= fifoQ.pop_front();
      end
      if (wrEn && fifoQ.size() < 8) fifoQ.push_back(wrData);
    end
    fifoCnt <= fifoQ.size();
  end

  assign bus.fifo_data      = fifoDout;
  assign bus.fifo_empty     = (fifoCnt == 0);
  assign bus.fifo_underflow = fifoUnderQ | forceUnder;
  assign bus.out_ready      = outReady;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    else passCount++;
  endtask

  // Reference model state, updated once per cycle at the falling edge.
  logic [7:0] modelQ[$];
  int   cyc = 0, doneAt = -1, beatIdx = 0, curLen = 0, startCyc = 0, latency = 0;
  int   firstBeatCyc = 0, lastBeatCyc = 0, rdCount = 0, underSeen = 0, toWrite = 0;
  bit   inBurst = 0, errExp = 0, sawDone = 0, firstValidSeen = 0, prevStall = 0, prevLast = 0;
  logic [7:0] prevData = 8'd0;

  task automatic sampleMonitor();
    bit idle;
    cyc++;
    if (rst) begin
      modelQ.delete();
      beatIdx = 0; curLen = 0; inBurst = 0; errExp = 0; doneAt = -1; prevStall = 0;
      return;
    end
    checkOutput("busy", busy, inBurst);
    checkOutput("done", done, cyc == doneAt);
    checkOutput("errUnderflow", errUnderflow, errExp);
    checkOutput("lastFlag", bus.out_last, bus.out_valid && (beatIdx == curLen - 1));
    if (bus.fifo_empty) checkOutput("rdWhileEmpty", bus.fifo_rd, 0);
    if (prevStall) begin
      checkOutput("holdValid", bus.out_valid, 1);
      checkOutput("holdData", bus.out_data, prevData);
      checkOutput("holdLast", bus.out_last, prevLast);
    end
    if (bus.fifo_rd) rdCount++;
    if (done) sawDone = 1;
    if (bus.out_valid && !firstValidSeen) begin
      firstValidSeen = 1;
      latency = cyc - startCyc;
    end
    idle = !inBurst && (cyc != doneAt);
    if (bus.fifo_underflow) begin
      underSeen++;
      if (inBurst) errExp = 1;
    end
    if (bus.out_valid && outReady) begin
      if (modelQ.size() == 0 || beatIdx >= curLen) begin
        checkOutput("beatUnexpected", bus.out_valid, 0);
      end else begin
        checkOutput("beatData", bus.out_data, modelQ.pop_front());
        checkOutput("beatCount", countSent, beatIdx);
        if (beatIdx == 0) firstBeatCyc = cyc;
        lastBeatCyc = cyc;
        beatIdx++;
        if (beatIdx == curLen) begin
          inBurst = 0;
          doneAt  = cyc + 1;
        end
      end
    end
    prevStall = bus.out_valid && !outReady;
    prevData  = bus.out_data;
    prevLast  = bus.out_last;
    if (start && idle) begin
      curLen = burstLen; beatIdx = 0; errExp = 0; startCyc = cyc; firstValidSeen = 0;
      inBurst = (burstLen != 0);
      if (burstLen == 0) doneAt = cyc + 1;
    end
    if (wrEn) modelQ.push_back(wrData);
    if (fifoClr) modelQ.delete();
  endtask

  // One clock cycle: sample at the falling edge, then release one-shot inputs after the rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    sampleMonitor();
    @(posedge clk);
    #1;
    start = 0; wrEn = 0; fifoClr = 0; forceUnder = 0;
  endtask

  task automatic writeWord(input logic [7:0] d);
    wrEn = 1; wrData = d;
    applyStimulus();
  endtask

  task automatic startBurst(input logic [7:0] len);
    start = 1; burstLen = len;
    applyStimulus();
  endtask

  task automatic waitDone(input int maxCycles, input bit randReady);
    sawDone = 0;
    for (int i = 0; i < maxCycles && !sawDone; i++) begin
      if (randReady) outReady = ($urandom_range(0, 3) != 0);
      if (toWrite > 0 && fifoCnt < 8 && $urandom_range(0, 2) != 0) begin
        wrEn = 1; wrData = 8'($urandom); toWrite--;
      end
      applyStimulus();
    end
    checkOutput("doneWithinBudget", sawDone, 1);
    outReady = 1;
  endtask

  initial begin
    applyStimulus();
    applyStimulus();
    rst = 0;
    applyStimulus();
    checkOutput("rstValid", bus.out_valid, 0);
    checkOutput("rstData", bus.out_data, 0);
    checkOutput("rstRd", bus.fifo_rd, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstCount", countSent, 0);
    checkOutput("rstErr", errUnderflow, 0);

    // Back-to-back burst of four preloaded words.
    outReady = 1;
    for (int i = 0; i < 4; i++) writeWord(8'h11 + 8'(i));
    rdCount = 0;
    startBurst(8'd4);
    waitDone(40, 0);
    checkOutput("t1Reads", rdCount, 4);
    checkOutput("t1Latency", latency, 3);
    checkOutput("t1BeatSpan", lastBeatCyc - firstBeatCyc, 3);
    checkOutput("t1Count", countSent, 4);
    checkOutput("t1Busy", busy, 0);

    // Eight words with the consumer stalled after the first valid beat.
    outReady = 0;
    for (int i = 0; i < 8; i++) writeWord(8'hA0 + 8'(i));
    rdCount = 0;
    startBurst(8'd8);
    for (int i = 0; i < 20 && !firstValidSeen; i++) applyStimulus();
    checkOutput("t2ValidSeen", firstValidSeen, 1);
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("t2StallReads", rdCount <= 2, 1);
    outReady = 1;
    waitDone(60, 0);
    checkOutput("t2Count", countSent, 8);
    checkOutput("t2Err", errUnderflow, 0);

    // FIFO runs dry mid-burst and is refilled later.
    underSeen = 0;
    for (int i = 0; i < 3; i++) writeWord(8'h30 + 8'(i));
    startBurst(8'd6);
    for (int i = 0; i < 10; i++) applyStimulus();
    for (int i = 0; i < 3; i++) writeWord(8'h40 + 8'(i));
    waitDone(60, 0);
    checkOutput("t3Count", countSent, 6);
    checkOutput("t3Underflow", underSeen, 0);

    // Zero-length burst with a word waiting in the FIFO.
    writeWord(8'h55);
    rdCount = 0;
    startBurst(8'd0);
    checkOutput("t4Done", done, 1);
    checkOutput("t4Count", countSent, 0);
    applyStimulus();
    checkOutput("t4Reads", rdCount, 0);

    // A start while busy must not change the burst.
    for (int i = 0; i < 3; i++) writeWord(8'h60 + 8'(i));
    startBurst(8'd3);
    applyStimulus();
    start = 1; burstLen = 8'd7;
    applyStimulus();
    waitDone(40, 0);
    checkOutput("t5Count", countSent, 3);

    // Reset two beats into a five-word burst.
    for (int i = 0; i < 5; i++) writeWord(8'h70 + 8'(i));
    startBurst(8'd5);
    for (int i = 0; i < 30 && beatIdx < 2; i++) applyStimulus();
    checkOutput("t6BeatsBeforeReset", beatIdx, 2);
    rst = 1; fifoClr = 1;
    applyStimulus();
    rst = 0;
    checkOutput("t6Valid", bus.out_valid, 0);
    checkOutput("t6Rd", bus.fifo_rd, 0);
    checkOutput("t6Busy", busy, 0);
    checkOutput("t6Count", countSent, 0);
    checkOutput("t6Done", done, 0);
    applyStimulus();

    // Underflow flag pulsed during RUN is sticky until the next accepted start.
    for (int i = 0; i < 4; i++) writeWord(8'h80 + 8'(i));
    startBurst(8'd4);
    forceUnder = 1;
    applyStimulus();
    waitDone(40, 0);
    checkOutput("t7ErrSticky", errUnderflow, 1);
    startBurst(8'd0);
    checkOutput("t7ErrCleared", errUnderflow, 0);
    applyStimulus();

    // Randomized bursts with random writes and random back-pressure.
    for (int b = 0; b < 20; b++) begin
      int len;
      len = $urandom_range(1, 12);
      toWrite = len;
      startBurst(8'(len));
      waitDone(600, 1);
      checkOutput("randCount", countSent, len);
      toWrite = 0;
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side master for the team's 8-deep synchronous FIFO. It drains a programmed number of words from the FIFO and forwards them on a valid/ready stream with a last marker. It drives the FIFO's rd strobe, never reads an empty FIFO, and absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer. It sits between the FIFO read port and downstream consumers such as packetisers or a UART TX.

Parameters:
DATA_W, 8, width of the FIFO data and the stream data
LEN_W, 8, width of the burst length and the sent counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  1-cycle request to begin a burst; sampled only in IDLE
burst_len  input  LEN_W  number of words to drain; sampled with start
fifo_rd  output  1  read strobe to the FIFO rd input
fifo_data  input  DATA_W  FIFO data_out; valid the cycle after an accepted read
fifo_empty  input  1  FIFO empty flag
fifo_underflow  input  1  FIFO underflow debug flag
out_valid  output  1  stream data valid
out_ready  input  1  downstream accept
out_data  output  DATA_W  stream data
out_last  output  1  high with the final beat of the burst
busy  output  1  high in RUN or DRAIN
done  output  1  1-cycle pulse when the burst completes
count_sent  output  LEN_W  beats handshaken in the current or last burst
err_underflow  output  1  sticky; cleared by an accepted start

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; all outputs 0 (fifo_rd, out_valid, out_data, out_last, busy, done, count_sent, err_underflow); skid buffer emptied; in-flight read flag cleared. Reset applies mid-burst with no completion pulse.
- Handshake: a beat transfers when out_valid && out_ready.
- Once out_valid is high, out_data and out_last hold stable until the beat transfers.
- Data order is strictly FIFO order.

State machine:
- IDLE:
  - start=1, burst_len>0: latch len; clear count_sent, issued count and err_underflow; go to RUN.
  - start=1, burst_len=0: go to DONE with no reads.
- RUN:
  - Issue reads as defined below.
  - When issued == len, go to DRAIN.
- DRAIN:
  - No reads are issued.
  - When the skid buffer is empty, no read is in flight and count_sent == len, go to DONE.
  - The DRAIN-to-DONE transition occurs on the clk edge of the final handshake.
- DONE: done=1 for exactly one cycle; go to IDLE.
- start outside IDLE is ignored.

Read issue (fifo_rd is combinational from registered state and inputs):
- fifo_rd = (state==RUN) && !fifo_empty && (issued < len) && (occ + pend - pop <= 1).
  - occ: skid buffer entries (0..2).
  - pend: a read issued last cycle (0/1).
  - pop: this cycle's handshake (0/1).
- fifo_rd is never high while fifo_empty=1.
- The skid buffer never overflows.
- Sustained throughput is 1 beat/cycle with out_ready held high.

Read data capture:
- A read issued in cycle t has fifo_data captured at the edge ending cycle t+1.
- The captured word is visible on out_data in cycle t+2.
- Latency from the start cycle to the first out_valid is 3 cycles when the FIFO is non-empty.

Counters and flags:
- out_last = out_valid && (count_sent == len-1).
- count_sent increments on each handshake. It holds after DONE until the next accepted start.
- issued and count_sent never exceed len; LEN_W arithmetic has no wrap within a burst.
- err_underflow sets if fifo_underflow=1 in any cycle while busy. It does not alter data flow.

Boundary conditions:
- FIFO goes empty mid-burst: RUN waits with fifo_rd=0. It resumes on the first cycle fifo_empty=0. There is no timeout.
- A simultaneous capture and pop in the same cycle keeps occ unchanged.

Test Plan:
- FIFO preloaded 0x11,0x12,0x13,0x14; start with len=4; out_ready=1.
  - Beats 11,12,13,14 on consecutive cycles; out_last only on 0x14.
  - fifo_rd high exactly 4 cycles.
  - done pulses one cycle after the 0x14 handshake; count_sent=4; busy returns 0.
- FIFO holds 8 words; len=8; out_ready low for 6 cycles after the first out_valid, then high.
  - fifo_rd high at most 2 times before out_ready rises; out_data holds stable while stalled.
  - All 8 words are delivered in order; err_underflow=0.
- len=6 with only 3 words present; 3 more are written 10 cycles later.
  - fifo_rd is never high while fifo_empty=1; fifo_underflow never asserts.
  - 6 beats with out_last on beat 6; then done.
- start with len=0 in IDLE: done pulses the next cycle; fifo_rd stays 0; count_sent=0.
- start pulsed while busy: ignored, and the burst length is unchanged.
- rst high for one cycle after 2 beats of a len=5 burst: the next cycle shows out_valid=0, fifo_rd=0, busy=0, count_sent=0, and no done pulse.
- fifo_underflow forced high for 1 cycle during RUN:
  - err_underflow=1 and stays high through DONE.
  - It clears on the next accepted start.
